// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial two's-complement subtractor (A - B), LSB first, one
//            full-adder cell per bit step, with borrow/overflow/zero flags.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0]       c_idle = 2'd0;
    localparam logic [1:0]       c_run  = 2'd1;
    localparam logic [1:0]       c_done = 2'd2;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_overflow;
    logic             r_zero;

    logic             w_b_inv;
    logic             w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_accept;
    logic             w_last;

    // Single full-adder cell: a + ~b + carry, carry seeded with 1 on accept
    assign w_b_inv   = ~r_b[0];
    assign w_sum     = r_a[0] ^ w_b_inv ^ r_carry;
    assign w_carry   = (r_a[0] & w_b_inv) | (r_a[0] & r_carry) | (w_b_inv & r_carry);
    assign w_res_nxt = {w_sum, r_res[WIDTH-1:1]};
    assign w_accept  = (r_state == c_idle) && start;
    assign w_last    = (r_state == c_run) && (r_cnt == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (start) w_state_nxt = c_run;
            c_run:   if (r_cnt == c_last) w_state_nxt = c_done;
            c_done:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_accept) begin
            // Published result and flags are left untouched until this operation ends
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (r_state == c_run) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_res   <= w_res_nxt;
            r_carry <= w_carry;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_diff     <= w_res_nxt;
                r_borrow   <= ~w_carry;
                r_overflow <= (r_a_msb != r_b_msb) && (w_res_nxt[WIDTH-1] != r_a_msb);
                r_zero     <= (w_res_nxt == '0);
            end
        end
    end

    assign busy       = (r_state == c_run);
    assign done       = (r_state == c_done);
    assign diff       = r_diff;
    assign borrow_out = r_borrow;
    assign overflow   = r_overflow;
    assign zero       = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Directed scoreboard bench for serial_subtractor, WIDTH=8 and 32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W8  = 8;
    localparam int W32 = 32;
    localparam int TMO = 100;

    logic           clk = 1'b0;
    logic           rst;
    logic           start8;
    logic [W8-1:0]  a8, b8, diff8;
    logic           busy8, done8, borrow8, ovf8, zero8;
    logic           start32;
    logic [W32-1:0] a32, b32, diff32;
    logic           busy32, done32, borrow32, ovf32, zero32;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8),
        .borrow_out(borrow8), .overflow(ovf8), .zero(zero8)
    );

    serial_subtractor #(.WIDTH(W32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .diff(diff32),
        .borrow_out(borrow32), .overflow(ovf32), .zero(zero32)
    );

    typedef struct packed {
        logic [31:0] diff;
        logic        borrow;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] last8 = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=none expected=event", tag);
    endtask

    function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] mask;
        logic [31:0] d;
        exp_t        e;
        mask     = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        d        = (x - y) & mask;
        e.diff   = d;
        e.borrow = ((x & mask) < (y & mask));
        e.ovf    = (x[w-1] != y[w-1]) && (d[w-1] != x[w-1]);
        e.zero   = (d == 32'd0);
        return e;
    endfunction

    task automatic check_out8(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            fail_now({tag, "_sb_empty"});
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_diff"},     {24'd0, diff8}, e.diff);
        check({tag, "_borrow"},   {31'd0, borrow8}, {31'd0, e.borrow});
        check({tag, "_overflow"}, {31'd0, ovf8},    {31'd0, e.ovf});
        check({tag, "_zero"},     {31'd0, zero8},   {31'd0, e.zero});
        last8 = e.diff;
    endtask

    task automatic wait_done8(input string tag, output int n);
        n = 0;
        while (done8 !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (done8 !== 1'b1) fail_now({tag, "_done_timeout"});
    endtask

    // One accepted operation on the 8-bit DUT, fully checked
    task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y);
        int nb;
        int n;
        @(negedge clk);
        start8 = 1'b1; a8 = x; b8 = y;
        sb_q.push_back(model(W8, {24'd0, x}, {24'd0, y}));
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        check({tag, "_busy"}, {31'd0, busy8}, 32'd1);
        check({tag, "_hold"}, {24'd0, diff8}, last8);
        nb = 1;
        n  = 0;
        while (done8 !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
            if (busy8) nb++;
        end
        if (done8 !== 1'b1) fail_now({tag, "_done_timeout"});
        check({tag, "_busycnt"}, nb, W8);
        check_out8(tag);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, done8}, 32'd0);
    endtask

    initial begin
        int   n;
        int   nb;
        logic seen;
        exp_t e;

        rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
        start32 = 1'b0; a32 = '0; b32 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",   {31'd0, busy8},   32'd0);
        check("rst_done",   {31'd0, done8},   32'd0);
        check("rst_diff",   {24'd0, diff8},   32'd0);
        check("rst_borrow", {31'd0, borrow8}, 32'd0);
        check("rst_ovf",    {31'd0, ovf8},    32'd0);
        check("rst_zero",   {31'd0, zero8},   32'd0);
        rst = 1'b0;

        run8("sub_5_3",    8'h05, 8'h03);
        run8("sub_3_5",    8'h03, 8'h05);
        run8("sub_80_01",  8'h80, 8'h01);
        run8("sub_a5_a5",  8'hA5, 8'hA5);
        run8("sub_00_00",  8'h00, 8'h00);
        run8("sub_ff_00",  8'hFF, 8'h00);
        run8("sub_7f_ff",  8'h7F, 8'hFF);

        // start held high, operands changed during RUN
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h40; b8 = 8'h10;
        sb_q.push_back(model(W8, 32'h40, 32'h10));
        @(negedge clk);
        a8 = 8'h21; b8 = 8'h42;
        sb_q.push_back(model(W8, 32'h21, 32'h42));
        wait_done8("b2b1", n);
        check_out8("b2b1");
        @(negedge clk);
        check("b2b_idle_busy", {31'd0, busy8}, 32'd0);
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_busy2", {31'd0, busy8}, 32'd1);
        wait_done8("b2b2", n);
        check("b2b_spacing", n + 2, W8 + 2);
        check_out8("b2b2");
        @(negedge clk);
        check("b2b_no_third", {31'd0, done8}, 32'd0);

        // Rebuild a nonzero result, then abort an operation at RUN cycle 4
        run8("pre_rst", 8'h7F, 8'hFF);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before", {31'd0, busy8}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy",   {31'd0, busy8},   32'd0);
        check("mid_rst_done",   {31'd0, done8},   32'd0);
        check("mid_rst_diff",   {24'd0, diff8},   32'd0);
        check("mid_rst_borrow", {31'd0, borrow8}, 32'd0);
        check("mid_rst_ovf",    {31'd0, ovf8},    32'd0);
        check("mid_rst_zero",   {31'd0, zero8},   32'd0);
        seen = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W8 + 4; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) seen = 1'b1;
        end
        check("mid_rst_no_done", {31'd0, seen}, 32'd0);
        last8 = 32'd0;
        run8("after_rst", 8'h09, 8'h04);

        // WIDTH=32 instance
        @(negedge clk);
        start32 = 1'b1; a32 = 32'd5; b32 = 32'd3;
        sb_q.push_back(model(W32, 32'd5, 32'd3));
        @(negedge clk);
        start32 = 1'b0; a32 = $urandom; b32 = $urandom;
        nb = (busy32 === 1'b1) ? 1 : 0;
        n  = 0;
        while (done32 !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
            if (busy32) nb++;
        end
        if (done32 !== 1'b1) fail_now("w32_done_timeout");
        check("w32_busycnt", nb, W32);
        if (sb_q.size() == 0) begin
            fail_now("w32_sb_empty");
        end else begin
            e = sb_q.pop_front();
            check("w32_diff",     diff32,             e.diff);
            check("w32_borrow",   {31'd0, borrow32},  {31'd0, e.borrow});
            check("w32_overflow", {31'd0, ovf32},     {31'd0, e.ovf});
            check("w32_zero",     {31'd0, zero32},    {31'd0, e.zero});
        end
        @(negedge clk);
        check("w32_pulse", {31'd0, done32}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
